// File: rtl/booth_pkg.sv
// Shared constants and types for the radix-4 Booth sequential multiplier.
// The early-termination build option is BOOTH_SEQ_EARLY_TERM_EN (used in booth_seq_mul).
package booth_pkg;

  localparam int OP_W   = 16;
  localparam int ITER_N = 8;
  localparam int CNT_W  = 4;
  localparam int ACC_W  = 2 * OP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic neg;
    logic zero;
    logic one;
    logic two;
  } booth_sel_t;

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: maps one overlapping 3-bit multiplier group to a
// {neg, zero, one, two} select.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output booth_sel_t sel
);

  // Booth group decode
  always_comb begin
    sel = '{neg: 1'b0, zero: 1'b1, one: 1'b0, two: 1'b0};
    case (grp)
      3'b000:  sel = '{neg: 1'b0, zero: 1'b1, one: 1'b0, two: 1'b0};
      3'b001:  sel = '{neg: 1'b0, zero: 1'b0, one: 1'b1, two: 1'b0};
      3'b010:  sel = '{neg: 1'b0, zero: 1'b0, one: 1'b1, two: 1'b0};
      3'b011:  sel = '{neg: 1'b0, zero: 1'b0, one: 1'b0, two: 1'b1};
      3'b100:  sel = '{neg: 1'b1, zero: 1'b0, one: 1'b0, two: 1'b1};
      3'b101:  sel = '{neg: 1'b1, zero: 1'b0, one: 1'b1, two: 1'b0};
      3'b110:  sel = '{neg: 1'b1, zero: 1'b0, one: 1'b1, two: 1'b0};
      3'b111:  sel = '{neg: 1'b0, zero: 1'b1, one: 1'b0, two: 1'b0};
      default: sel = '{neg: 1'b0, zero: 1'b1, one: 1'b0, two: 1'b0};
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential 16x16 signed radix-4 Booth multiplier, one group per RUN cycle.
// Define BOOTH_SEQ_EARLY_TERM_EN to leave RUN once every remaining group encodes zero.
module booth_seq_mul
  import booth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] prod,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W:0]      mreg_q, mreg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  booth_sel_t         sel_s;
  logic [ACC_W-1:0]   a_ext_s, mag_s, term_s;
  logic [OP_W:0]      mreg_shift_s;
  logic               accept_s, last_s, early_s;

  booth_enc u_enc (
    .grp (mreg_q[2:0]),
    .sel (sel_s)
  );

  // Partial-product term for the current group and the shifted multiplier
  always_comb begin
    a_ext_s = {{OP_W{a_q[OP_W-1]}}, a_q};
    if (sel_s.zero) begin
      mag_s = 32'd0;
    end else if (sel_s.two) begin
      mag_s = a_ext_s << 1;
    end else if (sel_s.one) begin
      mag_s = a_ext_s;
    end else begin
      mag_s = 32'd0;
    end
    if (sel_s.neg) begin
      term_s = ~mag_s + 32'd1;
    end else begin
      term_s = mag_s;
    end
    mreg_shift_s = {mreg_q[OP_W], mreg_q[OP_W], mreg_q[OP_W:2]};
    accept_s     = in_valid && (state_q == ST_IDLE);
    last_s       = (cnt_q == CNT_W'(ITER_N - 1));
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // All-zero or all-one multiplier left means every remaining group is zero
    early_s = (mreg_shift_s == 17'd0) || (mreg_shift_s == {17{1'b1}});
`else
    early_s = 1'b0;
`endif
  end

  // Datapath next values: load on accept, one Booth step per RUN cycle
  always_comb begin
    a_d    = a_q;
    mreg_d = mreg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (accept_s) begin
      a_d    = a;
      mreg_d = {b, 1'b0};
      acc_d  = 32'd0;
      cnt_d  = 4'd0;
    end else if (state_q == ST_RUN) begin
      acc_d  = acc_q + (term_s << {cnt_q[2:0], 1'b0});
      mreg_d = mreg_shift_s;
      cnt_d  = cnt_q + 4'd1;
    end else begin
      a_d    = a_q;
      mreg_d = mreg_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s || early_s) state_d = ST_DONE;
        else                   state_d = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= 16'd0;
      mreg_q  <= 17'd0;
      acc_q   <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mreg_q  <= mreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and result outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    prod      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        prod      = acc_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed corner cases plus random
// signed operand pairs against an arithmetic reference; honours BOOTH_SEQ_EARLY_TERM_EN.
module tb_booth_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_prod = 32'd0;
  logic        chk_en = 1'b0;

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  booth_seq_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    int sx, sy, p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return 32'(p);
  endfunction

  // Edge (counted from the accepting edge) at which out_valid is first sampled high
  function automatic int ref_lat(input logic [15:0] y);
    int sy, v;
    sy = $signed(y);
    if (EARLY) begin
      for (int k = 1; k <= 8; k++) begin
        v = sy >>> (2 * k - 1);
        if (v == 0 || v == -1) return k + 1;
      end
    end
    return 9;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %0s: got %h required %h", nm, act, req);
    end
  endtask

  // Per-cycle output check against the transaction model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (out_valid) check("prod_valid", prod, exp_prod);
      else           check("prod_zero_when_invalid", prod, 32'd0);
      check("busy_eq_not_ready", {31'd0, busy}, {31'd0, ~in_ready});
    end
  end

  task automatic do_mul(input logic [15:0] x, input logic [15:0] y, input int hold,
                        input bit use_lit, input logic [31:0] lit_prod, input int lit_lat);
    int n;
    @(negedge clk);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    exp_prod = ref_prod(x, y);
    n = 0;
    while (1) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      if (out_valid || n >= 20) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n + 1), 32'(ref_lat(y)));
    if (lit_lat > 0) check("latency_literal", 32'(n + 1), 32'(lit_lat));
    if (use_lit)     check("prod_literal", prod, lit_prod);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      check("hold_valid_not_ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    check("reset_prod", prod, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_mul(16'd3, 16'd5, 0, 1'b1, 32'h0000000F, EARLY ? 3 : 9);
    do_mul(16'h8000, 16'h8000, 0, 1'b1, 32'h40000000, 9);
    do_mul(16'h7FFF, 16'h8000, 0, 1'b1, 32'hC0008000, 9);
    do_mul(16'd3, 16'd5, 5, 1'b1, 32'h0000000F, EARLY ? 3 : 9);
    do_mul(16'd100, 16'd1, 0, 1'b1, 32'h00000064, EARLY ? 2 : 9);
    do_mul(16'd100, 16'hFFFF, 0, 1'b1, 32'hFFFFFF9C, EARLY ? 2 : 9);
    do_mul(16'd100, 16'h4000, 0, 1'b1, 32'h00190000, 9);

    // Abort in the 4th RUN cycle
    @(negedge clk);
    a = 16'd7; b = 16'h4001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("running_before_abort", {30'd0, busy, out_valid}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("abort_prod", prod, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_result_after_abort", {31'd0, out_valid}, 32'd0);
    end
    do_mul(16'd2, 16'd2, 0, 1'b1, 32'h00000004, EARLY ? 3 : 9);

    // Reset wins over a simultaneous accept
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'd5; b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("reset_over_accept", {30'd0, busy, in_ready}, 32'd1);

    for (int t = 0; t < 3000; t++) begin
      do_mul(pick(), pick(), $urandom_range(0, 2), 1'b0, 32'd0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
